// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing a single async-FIFO write port among NREQ producers.
// Each grant moves up to BURST words, stalls on write_full, and counts accepted words.
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  write_full,
  output logic [NREQ-1:0]       ack,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_data,
  output logic                  grant_valid,
  output logic [IDW-1:0]        grant_id,
  output logic [15:0]           word_count
);

  typedef enum logic {
    IDLE,
    XFER
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [3:0]     burst_cnt_q, burst_cnt_d;
  logic [15:0]    word_count_q, word_count_d;

  logic           wr;
  logic           wr_ok;
  logic           any_req;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] grant_next;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    any_req = 1'b0;
    pick    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!any_req && req[IDW'(idx)]) begin
        any_req = 1'b1;
        pick    = IDW'(idx);
      end
    end
  end

  assign grant_next = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

  assign wr = (state_q == XFER) && req[grant_id_q] && !write_full;
  // A reset edge must not commit a word into the FIFO.
  assign wr_ok = wr && !rst;

  always_comb begin
    ack = '0;
    if (wr_ok) ack[grant_id_q] = 1'b1;
  end

  assign fifo_wr_en  = wr_ok;
  assign fifo_data   = req_data[grant_id_q*WIDTH +: WIDTH];
  assign grant_valid = (state_q == XFER);
  assign grant_id    = grant_id_q;
  assign word_count  = word_count_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    burst_cnt_d  = burst_cnt_q;
    word_count_d = word_count_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_id_d  = pick;
          burst_cnt_d = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        if (!req[grant_id_q]) begin
          state_d  = IDLE;
          rr_ptr_d = grant_next;
        end else if (wr) begin
          burst_cnt_d  = burst_cnt_q + 4'd1;
          word_count_d = word_count_q + 16'd1;
          if (burst_cnt_q == 4'(BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = grant_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      burst_cnt_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      burst_cnt_q  <= burst_cnt_d;
      word_count_q <= word_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (NREQ=4, BURST=4) plus a
// second BURST=15 instance used to exercise the 16-bit word_count wrap.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        write_full;
  logic [3:0]  ack;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] word_count;

  fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .BURST(4)) dut (
    .wr_clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .write_full(write_full), .ack(ack), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .grant_valid(grant_valid), .grant_id(grant_id),
    .word_count(word_count)
  );

  logic        rst_w;
  logic [1:0]  req_w;
  logic [15:0] data_w;
  logic        full_w;
  logic [1:0]  ack_w;
  logic        wr_en_w;
  logic [7:0]  fifo_data_w;
  logic        gv_w;
  logic [0:0]  gid_w;
  logic [15:0] wc_w;

  fifo_wr_arbiter #(.WIDTH(8), .NREQ(2), .BURST(15)) u_wrap (
    .wr_clk(clk), .rst(rst_w), .req(req_w), .req_data(data_w),
    .write_full(full_w), .ack(ack_w), .fifo_wr_en(wr_en_w),
    .fifo_data(fifo_data_w), .grant_valid(gv_w), .grant_id(gid_w),
    .word_count(wc_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          seg;
    logic [3:0]  rq;
    bit          full;
    bit          wr;
    logic [3:0]  ack;
    logic [7:0]  data;
    bit          gv;
    logic [1:0]  gid;
    logic [15:0] wc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(bit seg, logic [3:0] rq, bit full, bit wr, int d,
                             bit gv, int gid, int wc);
    vec_t r;
    r.seg  = seg;
    r.rq   = rq;
    r.full = full;
    r.wr   = wr;
    r.ack  = wr ? 4'(1 << gid) : 4'b0000;
    r.data = 8'(d);
    r.gv   = gv;
    r.gid  = 2'(gid);
    r.wc   = 16'(wc);
    return r;
  endfunction

  // Producer model: each requester steps its data after every ack.
  logic [7:0] pdata [4];
  logic [3:0] prev_ack;
  int         base [4] = '{138, 202, 10, 74};

  task automatic apply_inputs(input logic [3:0] rq, input bit full);
    for (int i = 0; i < 4; i++)
      if (prev_ack[i]) pdata[i] = pdata[i] + 8'd1;
    req        = rq;
    write_full = full;
    req_data   = {pdata[3], pdata[2], pdata[1], pdata[0]};
    #1;
  endtask

  task automatic advance();
    prev_ack = ack;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req        = '0;
    write_full = 1'b0;
    prev_ack   = '0;
    for (int i = 0; i < 4; i++) pdata[i] = 8'(base[i]);
    req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant_valid", grant_valid, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_ack", ack, 0);
    check("rst_word_count", word_count, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_fifo_data", fifo_data, pdata[0]);
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int cyc;
    rst_w = 1'b1; req_w = '0; data_w = 16'h3C5A; full_w = 1'b0;
    rst = 1'b1; req = '0; write_full = 1'b0; req_data = '0; prev_ack = '0;

    // Single requester 2, two back-to-back bursts.
    tv.push_back(v(1, 4'b0100, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) tv.push_back(v(0, 4'b0100, 0, 1, 10 + k, 1, 2, k));
    tv.push_back(v(0, 4'b0100, 0, 0, 0, 0, 0, 4));
    for (int k = 0; k < 4; k++) tv.push_back(v(0, 4'b0100, 0, 1, 14 + k, 1, 2, 4 + k));
    tv.push_back(v(0, 4'b0000, 0, 0, 0, 0, 0, 8));
    tv.push_back(v(0, 4'b0000, 0, 0, 0, 0, 0, 8));

    // All requesters: grants 0,1,2,3,0 with one idle cycle between.
    tv.push_back(v(1, 4'b1111, 0, 0, 0, 0, 0, 0));
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++)
        tv.push_back(v(0, 4'b1111, 0, 1, base[g % 4] + (g / 4) * 4 + k, 1, g % 4, g * 4 + k));
      tv.push_back(v(0, 4'b1111, 0, 0, 0, 0, 0, (g + 1) * 4));
    end

    // Backpressure mid-grant to requester 1.
    tv.push_back(v(1, 4'b0010, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0010, 0, 1, 202, 1, 1, 0));
    tv.push_back(v(0, 4'b0010, 0, 1, 203, 1, 1, 1));
    for (int k = 0; k < 3; k++) tv.push_back(v(0, 4'b0010, 1, 0, 0, 1, 1, 2));
    tv.push_back(v(0, 4'b0010, 0, 1, 204, 1, 1, 2));
    tv.push_back(v(0, 4'b0010, 0, 1, 205, 1, 1, 3));
    tv.push_back(v(0, 4'b0000, 0, 0, 0, 0, 0, 4));

    // Early release by 3, then 1 ahead of 0, then release coinciding with full.
    tv.push_back(v(1, 4'b1000, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1010, 0, 1, 74, 1, 3, 0));
    tv.push_back(v(0, 4'b1010, 0, 1, 75, 1, 3, 1));
    tv.push_back(v(0, 4'b0010, 0, 0, 0, 1, 3, 2));
    tv.push_back(v(0, 4'b0010, 0, 0, 0, 0, 0, 2));
    tv.push_back(v(0, 4'b0010, 0, 1, 202, 1, 1, 2));
    tv.push_back(v(0, 4'b0011, 0, 1, 203, 1, 1, 3));
    tv.push_back(v(0, 4'b0011, 0, 1, 204, 1, 1, 4));
    tv.push_back(v(0, 4'b0011, 0, 1, 205, 1, 1, 5));
    tv.push_back(v(0, 4'b0011, 0, 0, 0, 0, 0, 6));
    tv.push_back(v(0, 4'b0011, 0, 1, 138, 1, 0, 6));
    tv.push_back(v(0, 4'b0000, 1, 0, 0, 1, 0, 7));
    tv.push_back(v(0, 4'b0000, 0, 0, 0, 0, 0, 7));

    foreach (tv[i]) begin
      if (tv[i].seg) do_reset();
      apply_inputs(tv[i].rq, tv[i].full);
      check($sformatf("v%0d_wr_en", i), fifo_wr_en, tv[i].wr);
      check($sformatf("v%0d_ack", i), ack, tv[i].ack);
      check($sformatf("v%0d_grant_valid", i), grant_valid, tv[i].gv);
      check($sformatf("v%0d_word_count", i), word_count, tv[i].wc);
      if (tv[i].gv) check($sformatf("v%0d_grant_id", i), grant_id, tv[i].gid);
      if (tv[i].wr) check($sformatf("v%0d_fifo_data", i), fifo_data, tv[i].data);
      advance();
    end

    // Reset during the third write of a grant to requester 2.
    do_reset();
    apply_inputs(4'b0100, 0);
    check("mr_idle", grant_valid, 0);
    advance();
    apply_inputs(4'b0100, 0);
    check("mr_w1_data", fifo_data, 10);
    check("mr_w1_en", fifo_wr_en, 1);
    advance();
    apply_inputs(4'b0100, 0);
    check("mr_w2_data", fifo_data, 11);
    advance();
    rst = 1'b1;
    apply_inputs(4'b0100, 0);
    check("mr_rst_no_wr", fifo_wr_en, 0);
    check("mr_rst_no_ack", ack, 0);
    check("mr_rst_wc_before", word_count, 2);
    advance();
    rst = 1'b0;
    apply_inputs(4'b1111, 0);
    check("mr_after_gv", grant_valid, 0);
    check("mr_after_wc", word_count, 0);
    check("mr_after_wr", fifo_wr_en, 0);
    advance();
    apply_inputs(4'b1111, 0);
    check("mr_regrant_gv", grant_valid, 1);
    check("mr_regrant_id", grant_id, 0);
    check("mr_regrant_data", fifo_data, 138);
    advance();
    req = '0;

    // word_count wrap on the BURST=15 instance.
    rst_w = 1'b0;
    req_w = 2'b01;
    cnt = 0;
    cyc = 0;
    while (cnt < 65535 && cyc < 80000) begin
      @(negedge clk); #1;
      if (wr_en_w) cnt++;
      cyc++;
    end
    check("wrap_write_count", cnt, 65535);
    @(negedge clk); #1;
    check("wrap_wc_ffff", wc_w, 16'hFFFF);
    cyc = 0;
    while (!wr_en_w && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("wrap_next_write", wr_en_w, 1);
    @(negedge clk); #1;
    check("wrap_wc_zero", wc_w, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
